muldiv_seq: RTL and testbench

Parametrised iterative multiply/divide unit for the execute stage. It replaces the fixed 32-bit combinational multiplier and the separate divider with one sequential engine that computes either a signed/unsigned product or a quotient/remainder into HI/LO. It uses a start/ready/annul handshake, so the hazard unit can stall the pipeline while it is busy and cancel it on a flush.

---
 rtl/muldiv_seq_if.sv | 27 ++
 rtl/muldiv_seq.sv | 168 ++++++++++++++++
 tb/tb_muldiv_seq.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// Start/ready/annul handshake bundle for the iterative multiply/divide engine.
// The master side issues operations; the slave side is the engine itself.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic             sign;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             annul;
  logic             busy;
  logic             ready;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             dbz;

  modport master (
    output start, op, sign, a, b, annul,
    input  busy, ready, hi, lo, dbz
  );

  modport slave (
    input  start, op, sign, a, b, annul,
    output busy, ready, hi, lo, dbz
  );
endinterface

// File: rtl/muldiv_seq.sv
// Sequential multiply/divide engine: one operand bit per cycle over magnitudes,
// then a single sign-correction cycle before results land in hi/lo.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  muldiv_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic             opDiv_r, sgn_r, aNeg_r, bNeg_r, bZero_r;
  logic [WIDTH-1:0] aOrig_r, opnd_r, accLo_r;
  logic [WIDTH:0]   accHi_r;
  logic             busy_r, ready_r, dbz_r;
  logic [WIDTH-1:0] hi_r, lo_r;

  logic [WIDTH-1:0]   magA_s, magB_s;
  logic [WIDTH:0]     mulSum_s, mulAdd_s, divShift_s, divDiff_s, accHiNext_s;
  logic [WIDTH-1:0]   accLoNext_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   hiFix_s, loFix_s;
  logic               dbzFix_s;

  // Operand magnitudes taken at acceptance; most-negative maps onto itself as unsigned.
  always_comb begin
    if (bus.sign && bus.a[WIDTH-1]) magA_s = -bus.a;
    else                            magA_s = bus.a;
    if (bus.sign && bus.b[WIDTH-1]) magB_s = -bus.b;
    else                            magB_s = bus.b;
  end

  // One iteration: accHi/accLo act as product shift pair or as remainder/quotient pair.
  always_comb begin
    mulSum_s   = accHi_r + {1'b0, opnd_r};
    mulAdd_s   = accLo_r[0] ? mulSum_s : accHi_r;
    divShift_s = {accHi_r[WIDTH-1:0], accLo_r[WIDTH-1]};
    divDiff_s  = divShift_s - {1'b0, opnd_r};
    if (opDiv_r) begin
      if (divDiff_s[WIDTH]) begin
        accHiNext_s = divShift_s;
        accLoNext_s = {accLo_r[WIDTH-2:0], 1'b0};
      end else begin
        accHiNext_s = divDiff_s;
        accLoNext_s = {accLo_r[WIDTH-2:0], 1'b1};
      end
    end else begin
      accHiNext_s = {1'b0, mulAdd_s[WIDTH:1]};
      accLoNext_s = {mulAdd_s[0], accLo_r[WIDTH-1:1]};
    end
  end

  // Sign correction and divide-by-zero override applied while in FIX.
  always_comb begin
    prod_s   = {accHi_r[WIDTH-1:0], accLo_r};
    hiFix_s  = hi_r;
    loFix_s  = lo_r;
    dbzFix_s = 1'b0;
    if (!opDiv_r) begin
      if (sgn_r && (aNeg_r ^ bNeg_r)) {hiFix_s, loFix_s} = -prod_s;
      else                            {hiFix_s, loFix_s} = prod_s;
    end else if (bZero_r) begin
      hiFix_s  = aOrig_r;
      loFix_s  = {WIDTH{1'b1}};
      dbzFix_s = 1'b1;
    end else begin
      if (sgn_r && (aNeg_r ^ bNeg_r)) loFix_s = -accLo_r;
      else                            loFix_s = accLo_r;
      if (sgn_r && aNeg_r)            hiFix_s = -accHi_r[WIDTH-1:0];
      else                            hiFix_s = accHi_r[WIDTH-1:0];
    end
  end

  // Control FSM with registered busy/ready and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      opDiv_r <= 1'b0;
      sgn_r   <= 1'b0;
      aNeg_r  <= 1'b0;
      bNeg_r  <= 1'b0;
      bZero_r <= 1'b0;
      aOrig_r <= {WIDTH{1'b0}};
      opnd_r  <= {WIDTH{1'b0}};
      accHi_r <= {(WIDTH+1){1'b0}};
      accLo_r <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      ready_r <= 1'b0;
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
      dbz_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ready_r <= 1'b0;
          if (bus.start && !bus.annul) begin
            opDiv_r <= bus.op;
            sgn_r   <= bus.sign;
            aNeg_r  <= bus.a[WIDTH-1];
            bNeg_r  <= bus.b[WIDTH-1];
            bZero_r <= (bus.b == {WIDTH{1'b0}});
            aOrig_r <= bus.a;
            opnd_r  <= bus.op ? magB_s : magA_s;
            accHi_r <= {(WIDTH+1){1'b0}};
            accLo_r <= bus.op ? magA_s : magB_s;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (bus.annul) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            accHi_r <= accHiNext_s;
            accLo_r <= accLoNext_s;
            cnt_r   <= cnt_r + CW'(1);
            if (cnt_r == LAST_CNT) state_r <= FIX;
            else                   state_r <= RUN;
          end
        end
        FIX: begin
          if (bus.annul) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            hi_r    <= hiFix_s;
            lo_r    <= loFix_s;
            dbz_r   <= dbzFix_s;
            ready_r <= 1'b1;
            state_r <= DONE;
          end
        end
        DONE: begin
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_r;
  assign bus.ready = ready_r;
  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;
  assign bus.dbz   = dbz_r;
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq at WIDTH=32 and WIDTH=8: directed table,
// randomized operations against an arithmetic reference, annul and reset sequences.
module tb_muldiv_seq;
  logic clk;
  logic rst;

  muldiv_seq_if #(.WIDTH(32)) m32 ();
  muldiv_seq_if #(.WIDTH(8))  m8 ();

  muldiv_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(m32));
  muldiv_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(m8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } res_t;

  typedef struct packed {
    logic        op;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  int vecCnt  = 0;
  int missCnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecCnt++;
    if (act !== exp) begin
      missCnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit operands held in 64-bit containers.
  function automatic res_t model(input int w, input logic op, input logic sgn,
                                 input logic [31:0] a, input logic [31:0] b);
    longint unsigned mask, ua, ub, p;
    longint          sa, sb, q, r;
    res_t            res;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'd0, a} & mask;
    ub   = {32'd0, b} & mask;
    sa   = $signed(ua << (64 - w)) >>> (64 - w);
    sb   = $signed(ub << (64 - w)) >>> (64 - w);
    res.dbz = 1'b0;
    if (!op) begin
      if (sgn) p = sa * sb;
      else     p = ua * ub;
      res.lo = 32'(p & mask);
      res.hi = 32'((p >> w) & mask);
    end else if (ub == 64'd0) begin
      res.hi  = 32'(ua);
      res.lo  = 32'(mask);
      res.dbz = 1'b1;
    end else if (sgn) begin
      q = sa / sb;
      r = sa % sb;
      res.lo = 32'(q & mask);
      res.hi = 32'(r & mask);
    end else begin
      res.lo = 32'((ua / ub) & mask);
      res.hi = 32'((ua % ub) & mask);
    end
    return res;
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one 32-bit operation, scramble inputs (start included) during RUN, check result and timing.
  task automatic doOp32(input string name, input logic op, input logic sgn,
                        input logic [31:0] a, input logic [31:0] b, input res_t exp);
    int cyc;
    m32.op = op; m32.sign = sgn; m32.a = a; m32.b = b; m32.start = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    check({name, " busy@1"}, 64'(m32.busy), 64'd1);
    for (int i = 0; i < 3; i++) begin
      m32.start = 1'($urandom);
      m32.op    = 1'($urandom);
      m32.sign  = 1'($urandom);
      m32.a     = $urandom;
      m32.b     = $urandom;
      @(posedge clk); #1;
      cyc++;
    end
    m32.start = 1'b0;
    while (m32.ready !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, " latency"}, 64'(cyc), 64'd34);
    check({name, " hi"}, 64'(m32.hi), 64'(exp.hi));
    check({name, " lo"}, 64'(m32.lo), 64'(exp.lo));
    check({name, " dbz"}, 64'(m32.dbz), 64'(exp.dbz));
    @(posedge clk); #1;
    check({name, " idle busy/ready"}, 64'({m32.busy, m32.ready}), 64'd0);
    check({name, " hi held"}, 64'(m32.hi), 64'(exp.hi));
  endtask

  task automatic doOp8(input string name, input logic op, input logic sgn,
                       input logic [7:0] a, input logic [7:0] b);
    int   cyc;
    res_t exp;
    exp = model(8, op, sgn, {24'd0, a}, {24'd0, b});
    m8.op = op; m8.sign = sgn; m8.a = a; m8.b = b; m8.start = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    m8.start = 1'b0;
    while (m8.ready !== 1'b1 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, " latency"}, 64'(cyc), 64'd10);
    check({name, " hi"}, 64'(m8.hi), 64'(exp.hi[7:0]));
    check({name, " lo"}, 64'(m8.lo), 64'(exp.lo[7:0]));
    check({name, " dbz"}, 64'(m8.dbz), 64'(exp.dbz));
    @(posedge clk); #1;
  endtask

  // Start a divide, annul it while sampled in cycle k, expect silent return to idle.
  task automatic annulAt(input string name, input int k);
    logic [31:0] prevHi, prevLo;
    logic        prevDbz, seen;
    int          cyc;
    prevHi = m32.hi; prevLo = m32.lo; prevDbz = m32.dbz;
    m32.op = 1'b1; m32.sign = 1'b0; m32.a = $urandom; m32.b = 32'd3; m32.start = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    m32.start = 1'b0;
    seen = m32.ready;
    while (cyc < k) begin
      @(posedge clk); #1;
      cyc++;
      seen = seen | m32.ready;
    end
    m32.annul = 1'b1;
    @(posedge clk); #1;
    m32.annul = 1'b0;
    seen = seen | m32.ready;
    check({name, " busy"}, 64'(m32.busy), 64'd0);
    check({name, " no ready"}, 64'(seen), 64'd0);
    check({name, " hi/lo/dbz held"}, {m32.hi, m32.lo} ^ 64'(m32.dbz != prevDbz),
          {prevHi, prevLo});
  endtask

  vec_t tbl [0:9];
  res_t e;
  logic rop, rsg;
  logic [31:0] ra, rb;
  logic seenR;

  initial begin
    tbl[0] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    tbl[5] = '{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b0};

    m32.start = 1'b0; m32.op = 1'b0; m32.sign = 1'b0; m32.a = 32'd0; m32.b = 32'd0; m32.annul = 1'b0;
    m8.start  = 1'b0; m8.op  = 1'b0; m8.sign  = 1'b0; m8.a  = 8'd0;  m8.b  = 8'd0;  m8.annul  = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset32 outputs", {m32.hi, m32.lo} | 64'({m32.busy, m32.ready, m32.dbz}), 64'd0);
    check("reset8 outputs", 64'({m8.hi, m8.lo, m8.busy, m8.ready, m8.dbz}), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed vectors.
    for (int i = 0; i < 10; i++) begin
      e.hi = tbl[i].hi; e.lo = tbl[i].lo; e.dbz = tbl[i].dbz;
      doOp32($sformatf("vec%0d", i), tbl[i].op, tbl[i].sgn, tbl[i].a, tbl[i].b, e);
    end

    // Start together with annul in IDLE is ignored.
    m32.op = 1'b0; m32.a = 32'd5; m32.b = 32'd5; m32.start = 1'b1; m32.annul = 1'b1;
    @(posedge clk); #1;
    m32.start = 1'b0; m32.annul = 1'b0;
    check("start+annul idle", 64'(m32.busy), 64'd0);

    // Annul in RUN at cycle 10, restart at cycle 12.
    annulAt("annul@10", 10);
    @(posedge clk); #1;
    doOp32("restart", 1'b1, 1'b0, 32'd1000, 32'd3, model(32, 1'b1, 1'b0, 32'd1000, 32'd3));
    annulAt("annul@FIX", 33);
    annulAt("annul@1", 1);

    // Randomized operations against the reference.
    for (int i = 0; i < 40; i++) begin
      rop = 1'($urandom); rsg = 1'($urandom);
      ra = pick32(); rb = pick32();
      doOp32($sformatf("rnd%0d", i), rop, rsg, ra, rb, model(32, rop, rsg, ra, rb));
    end

    // Narrow instance: directed corner then random.
    doOp8("w8 umul max", 1'b0, 1'b0, 8'hFF, 8'hFF);
    check("w8 corner hi/lo", 64'({m8.hi, m8.lo}), 64'h0000_FE01);
    doOp8("w8 sdiv ovf", 1'b1, 1'b1, 8'h80, 8'hFF);
    doOp8("w8 dbz", 1'b1, 1'b0, 8'h5A, 8'h00);
    for (int i = 0; i < 30; i++) begin
      doOp8($sformatf("w8 rnd%0d", i), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
    end

    // Reset in cycle 20 of a running multiply.
    doOp32("pre-reset", 1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF1,
           model(32, 1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF1));
    m32.op = 1'b0; m32.sign = 1'b0; m32.a = 32'hDEAD_BEEF; m32.b = 32'h0000_0003; m32.start = 1'b1;
    @(posedge clk); #1;
    m32.start = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async reset hi", 64'(m32.hi), 64'd0);
    check("async reset lo", 64'(m32.lo), 64'd0);
    check("async reset flags", 64'({m32.busy, m32.ready, m32.dbz}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    seenR = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      seenR = seenR | m32.ready | m32.busy;
    end
    check("post-reset quiet", 64'(seenR), 64'd0);
    doOp32("after reset", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           model(32, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF));

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end
endmodule
